bcd_down_counter: RTL and testbench

//  Multi-digit synchronous BCD down-counter (countdown timer): counterpart of
//  the BCD up-counter. Loads a BCD preset, decrements one count per enabled

---
 rtl/bcd_down_counter.sv | 104 ++++++++++
 tb/tb_bcd_down_counter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_counter.sv
// Multi-digit synchronous BCD down-counter with clamped preset load, decimal
// borrow between digits, terminal-zero flag and a one-cycle done pulse.
module bcd_down_counter #(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  output logic [4*DIGITS-1:0] count,
  output logic                zero,
  output logic                done
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] preset_q, preset_d;
  logic         zero_q, zero_d;
  logic         done_q, done_d;
  logic         count_is_zero_s;
  logic         count_is_one_s;

  // Force every digit into 0..9 so the counter never holds an illegal code.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Subtract one with a borrow rippling upward through digits that are 0.
  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!borrow) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        borrow      = 1'b0;
      end
    end
    return r;
  endfunction

  assign count_is_zero_s = (count_q == {W{1'b0}});
  assign count_is_one_s  = (count_q == {{(W-1){1'b0}}, 1'b1});

  // Next-state selection: load beats en; en at zero either holds or reloads.
  always_comb begin
    count_d  = count_q;
    preset_d = preset_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = clamp_bcd(load_val);
      preset_d = clamp_bcd(load_val);
    end else if (en) begin
      if (!count_is_zero_s) begin
        count_d = dec_bcd(count_q);
        done_d  = count_is_one_s;
      end else if (AUTO_RELOAD) begin
        count_d = preset_q;
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
    zero_d = (count_d == {W{1'b0}});
  end

  // State registers with synchronous reset that also clears the preset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= {W{1'b0}};
      preset_q <= {W{1'b0}};
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      preset_q <= preset_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign zero  = zero_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench: three counter variants against an integer-arithmetic
// reference model, directed scenarios followed by randomized traffic.
module tb_bcd_down_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // a: DIGITS=2 halt, b: DIGITS=3 halt, c: DIGITS=2 auto-reload
  logic        rst_a = 1'b0, load_a = 1'b0, en_a = 1'b0;
  logic [7:0]  val_a = 8'h00, cnt_a;
  logic        zero_a, done_a;
  logic        rst_b = 1'b0, load_b = 1'b0, en_b = 1'b0;
  logic [11:0] val_b = 12'h000, cnt_b;
  logic        zero_b, done_b;
  logic        rst_c = 1'b0, load_c = 1'b0, en_c = 1'b0;
  logic [7:0]  val_c = 8'h00, cnt_c;
  logic        zero_c, done_c;

  bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b0)) u_a (
    .clk(clk), .reset(rst_a), .load(load_a), .load_val(val_a), .en(en_a),
    .count(cnt_a), .zero(zero_a), .done(done_a));
  bcd_down_counter #(.DIGITS(3), .AUTO_RELOAD(1'b0)) u_b (
    .clk(clk), .reset(rst_b), .load(load_b), .load_val(val_b), .en(en_b),
    .count(cnt_b), .zero(zero_b), .done(done_b));
  bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b1)) u_c (
    .clk(clk), .reset(rst_c), .load(load_c), .load_val(val_c), .en(en_c),
    .count(cnt_c), .zero(zero_c), .done(done_c));

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt[3];
  int m_pre[3];
  bit m_zero[3];
  bit m_done[3];
  int dg[3] = '{2, 3, 2};
  bit ar[3] = '{1'b0, 1'b0, 1'b1};

  // Decimal value of a BCD word after clamping each digit to 9.
  function automatic int bcd_value(input logic [31:0] v, input int d);
    int s, p, n;
    s = 0;
    p = 1;
    for (int i = 0; i < d; i++) begin
      n = int'(v[4*i +: 4]);
      if (n > 9) n = 9;
      s = s + n * p;
      p = p * 10;
    end
    return s;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = 32'h0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void model_step(input int k, input logic rs, input logic ld,
                                     input logic [31:0] lv, input logic e);
    if (rs) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_done[k] = 1'b0;
    end else if (ld) begin
      m_cnt[k] = bcd_value(lv, dg[k]); m_pre[k] = m_cnt[k]; m_done[k] = 1'b0;
    end else if (e && m_cnt[k] > 0) begin
      m_cnt[k] = m_cnt[k] - 1; m_done[k] = (m_cnt[k] == 0);
    end else if (e) begin
      m_done[k] = 1'b0;
      if (ar[k]) m_cnt[k] = m_pre[k];
    end else begin
      m_done[k] = 1'b0;
    end
    m_zero[k] = (m_cnt[k] == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, rst_a, load_a, {24'h0, val_a}, en_a);
    model_step(1, rst_b, load_b, {20'h0, val_b}, en_b);
    model_step(2, rst_c, load_c, {24'h0, val_c}, en_c);
    #1;
  endtask

  task automatic idle_all();
    rst_a = 1'b0; load_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; load_b = 1'b0; en_b = 1'b0;
    rst_c = 1'b0; load_c = 1'b0; en_c = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; load_a = 1'b1; val_a = 8'h55;
    tick();
    idle_all();
    tick();
    n_checks++;
    if (cnt_a !== 8'h00 || zero_a !== 1'b1 || done_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_a: got cnt=%h z=%b d=%b want 00 1 0", cnt_a, zero_a, done_a);
    end
    n_checks++;
    if (cnt_b !== 12'h000 || zero_b !== 1'b1 || done_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_b: got cnt=%h z=%b d=%b want 000 1 0", cnt_b, zero_b, done_b);
    end
    n_checks++;
    if (cnt_c !== 8'h00 || zero_c !== 1'b1 || done_c !== 1'b0) begin
      n_fail++; $display("FAIL reset_c: got cnt=%h z=%b d=%b want 00 1 0", cnt_c, zero_c, done_c);
    end
  endtask

  task automatic test_countdown();
    logic [31:0] exp;
    load_a = 1'b1; val_a = 8'h12; en_a = 1'b1;
    tick();
    load_a = 1'b0;
    n_checks++;
    if (cnt_a !== 8'h12 || zero_a !== 1'b0) begin
      n_fail++; $display("FAIL countdown_load: got %h z=%b want 12 0", cnt_a, zero_a);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      exp = to_bcd(m_cnt[0]);
      n_checks++;
      if (cnt_a !== exp[7:0] || zero_a !== m_zero[0] || done_a !== m_done[0]) begin
        n_fail++;
        $display("FAIL countdown_step%0d: got %h z=%b d=%b want %h z=%b d=%b",
                 i, cnt_a, zero_a, done_a, exp[7:0], m_zero[0], m_done[0]);
      end
      n_checks++;
      if (done_a !== (i == 11)) begin
        n_fail++; $display("FAIL countdown_done%0d: got %b want %b", i, done_a, (i == 11));
      end
    end
    idle_all();
  endtask

  task automatic test_borrow();
    load_b = 1'b1; val_b = 12'h100;
    tick();
    load_b = 1'b0; en_b = 1'b1;
    tick();
    en_b = 1'b0;
    n_checks++;
    if (cnt_b !== 12'h099 || zero_b !== 1'b0) begin
      n_fail++; $display("FAIL borrow_100: got %h want 099", cnt_b);
    end
    load_b = 1'b1; val_b = 12'h1F9;
    tick();
    load_b = 1'b0;
    n_checks++;
    if (cnt_b !== 12'h199) begin
      n_fail++; $display("FAIL clamp_1F9: got %h want 199", cnt_b);
    end
    load_b = 1'b1; val_b = 12'h000; en_b = 1'b1;
    tick();
    idle_all();
    n_checks++;
    if (cnt_b !== 12'h000 || zero_b !== 1'b1 || done_b !== 1'b0) begin
      n_fail++; $display("FAIL load_zero: got %h z=%b d=%b want 000 1 0", cnt_b, zero_b, done_b);
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_cnt [8] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    bit         exp_done[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    load_c = 1'b1; val_c = 8'h03;
    tick();
    load_c = 1'b0; en_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (cnt_c !== exp_cnt[i] || done_c !== exp_done[i] || zero_c !== (exp_cnt[i] == 8'h00)) begin
        n_fail++;
        $display("FAIL reload_step%0d: got %h d=%b z=%b want %h d=%b", i, cnt_c, done_c, zero_c,
                 exp_cnt[i], exp_done[i]);
      end
    end
    idle_all();
  endtask

  task automatic test_priority();
    load_a = 1'b1; val_a = 8'h05;
    tick();
    val_a = 8'h42; en_a = 1'b1;
    tick();
    n_checks++;
    if (cnt_a !== 8'h42) begin
      n_fail++; $display("FAIL load_over_en: got %h want 42", cnt_a);
    end
    rst_a = 1'b1;
    tick();
    idle_all();
    n_checks++;
    if (cnt_a !== 8'h00 || zero_a !== 1'b1) begin
      n_fail++; $display("FAIL reset_over_load: got %h z=%b want 00 1", cnt_a, zero_a);
    end
  endtask

  task automatic test_reset_midrun();
    load_c = 1'b1; val_c = 8'h40;
    tick();
    load_c = 1'b0; en_c = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (cnt_c !== 8'h37) begin
      n_fail++; $display("FAIL midrun_count: got %h want 37", cnt_c);
    end
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    n_checks++;
    if (cnt_c !== 8'h00 || zero_c !== 1'b1) begin
      n_fail++; $display("FAIL midrun_reset: got %h z=%b want 00 1", cnt_c, zero_c);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (cnt_c !== 8'h00 || zero_c !== 1'b1 || done_c !== 1'b0) begin
        n_fail++; $display("FAIL midrun_hold%0d: got %h z=%b d=%b want 00 1 0", i, cnt_c, zero_c, done_c);
      end
    end
    idle_all();
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, ec;
    for (int i = 0; i < 600; i++) begin
      rst_a  = ($urandom_range(0, 40) == 0);
      load_a = ($urandom_range(0, 12) == 0);
      val_a  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 6));
      en_a   = ($urandom_range(0, 3) != 0);
      rst_b  = ($urandom_range(0, 40) == 0);
      load_b = ($urandom_range(0, 12) == 0);
      val_b  = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'($urandom_range(0, 12));
      en_b   = ($urandom_range(0, 3) != 0);
      rst_c  = ($urandom_range(0, 40) == 0);
      load_c = ($urandom_range(0, 12) == 0);
      val_c  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 6));
      en_c   = ($urandom_range(0, 3) != 0);
      tick();
      ea = to_bcd(m_cnt[0]);
      eb = to_bcd(m_cnt[1]);
      ec = to_bcd(m_cnt[2]);
      n_checks++;
      if (cnt_a !== ea[7:0] || zero_a !== m_zero[0] || done_a !== m_done[0]) begin
        n_fail++; $display("FAIL rand_a%0d: got %h z=%b d=%b want %h z=%b d=%b",
                           i, cnt_a, zero_a, done_a, ea[7:0], m_zero[0], m_done[0]);
      end
      n_checks++;
      if (cnt_b !== eb[11:0] || zero_b !== m_zero[1] || done_b !== m_done[1]) begin
        n_fail++; $display("FAIL rand_b%0d: got %h z=%b d=%b want %h z=%b d=%b",
                           i, cnt_b, zero_b, done_b, eb[11:0], m_zero[1], m_done[1]);
      end
      n_checks++;
      if (cnt_c !== ec[7:0] || zero_c !== m_zero[2] || done_c !== m_done[2]) begin
        n_fail++; $display("FAIL rand_c%0d: got %h z=%b d=%b want %h z=%b d=%b",
                           i, cnt_c, zero_c, done_c, ec[7:0], m_zero[2], m_done[2]);
      end
    end
    idle_all();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_zero[k] = 1'b1; m_done[k] = 1'b0;
    end
    #2;
    test_reset();
    test_countdown();
    test_borrow();
    test_auto_reload();
    test_priority();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
